bytewrite_tdp_ram_modes: RTL

//  Single-clock true-dual-port RAM with per-column (byte-wide) write enables.

---
 rtl/bytewrite_tdp_ram_modes_pkg.sv | 24 ++
 rtl/bytewrite_tdp_ram_modes_if.sv | 21 ++
 rtl/bytewrite_tdp_ram_modes_outreg.sv | 38 +++
 rtl/bytewrite_tdp_ram_modes.sv | 116 +++++++++++
 4 files changed

// File: rtl/bytewrite_tdp_ram_modes_pkg.sv
// Shared definitions for the byte-write true-dual-port RAM.
//  - read-mode encodings for READ_MODE
//  - col_slice(): extract one column from a word (zero-extended to MAX_WORD_W)
package bytewrite_ram_pkg;

  localparam int RM_WRITE_FIRST = 0;
  localparam int RM_READ_FIRST  = 1;
  localparam int RM_NO_CHANGE   = 2;

  // Widest word col_slice accepts; callers zero-extend into it and truncate
  // the result back to their column width.
  localparam int MAX_WORD_W = 1024;

  function automatic logic [MAX_WORD_W-1:0] col_slice(
    input logic [MAX_WORD_W-1:0] word,
    input int                    idx,
    input int                    col_w = 8
  );
    logic [MAX_WORD_W-1:0] mask;
    mask = (MAX_WORD_W'(1) << col_w) - MAX_WORD_W'(1);
    return (word >> (idx * col_w)) & mask;
  endfunction

endpackage

// File: rtl/bytewrite_tdp_ram_modes_if.sv
// One RAM access port: enable, column write enables, address, write data,
// read data and read-valid.
//  master: drives the request (ena/we/addr/din), receives dout/dout_vld
//  slave : the RAM side
interface bytewrite_ram_port_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  ena;
  logic [NUM_COL-1:0]    we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;

  modport master (output ena, we, addr, din, input  dout, dout_vld);
  modport slave  (input  ena, we, addr, din, output dout, dout_vld);
endinterface

// File: rtl/bytewrite_tdp_ram_modes_outreg.sv
// Optional output stage for one RAM port: dout, vld and the collision flag.
// With OUT_REG=0 the inputs pass straight through (the flops are left
// unloaded and trimmed by synthesis).
//  clk, rst_n      clock, synchronous active-low reset
//  din/vld_in/coll_in   first-stage read data, valid, collision
//  dout/vld/coll        port outputs
module bytewrite_ram_outreg #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  vld_in,
  input  logic                  coll_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  vld,
  output logic                  coll
);
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  vld_q, coll_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      dout_q <= din;
      vld_q  <= vld_in;
      coll_q <= coll_in;
    end
  end

  assign dout = (OUT_REG != 0) ? dout_q : din;
  assign vld  = (OUT_REG != 0) ? vld_q  : vld_in;
  assign coll = (OUT_REG != 0) ? coll_q : coll_in;
endmodule

// File: rtl/bytewrite_tdp_ram_modes.sv
// Single-clock true-dual-port RAM with per-column write enables and a
// selectable read-during-write mode (write-first / read-first / no-change).
//  clk, rst_n   clock, synchronous active-low reset (memory is not cleared)
//  port_a/b     access ports (ena, we, addr, din -> dout, dout_vld)
//  coll         same-address access with at least one write, aligned to dout
// Read latency is 1 + OUT_REG. Same-column same-address writes are resolved
// in favour of port A when PRIO_A=1, port B otherwise.
module bytewrite_tdp_ram_modes
  import bytewrite_ram_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_MODE  = RM_WRITE_FIRST,
  parameter int OUT_REG    = 0,
  parameter int PRIO_A     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bytewrite_ram_port_if.slave  port_a,
  bytewrite_ram_port_if.slave  port_b,
  output logic                 coll
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  if (READ_MODE < 0 || READ_MODE > 2) begin : g_bad_mode
    $error("READ_MODE must be 0, 1 or 2");
  end
  if (DATA_WIDTH > MAX_WORD_W) begin : g_bad_width
    $error("word wider than MAX_WORD_W");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                             ena_a, ena_b, same_addr;
  logic [NUM_COL-1:0]               wr_a, wr_b;
  logic [NUM_COL-1:0][COL_WIDTH-1:0] col_a, col_b;
  logic [DATA_WIDTH-1:0]            old_a, old_b, new_a, new_b, rd_a, rd_b;
  logic                             hold_a, hold_b;
  logic [DATA_WIDTH-1:0]            dout1_a, dout1_b;
  logic                             vld1_a, vld1_b, coll1, coll_a, coll_b;

  // Enables are gated by reset so nothing is written while rst_n is low.
  assign ena_a     = port_a.ena & rst_n;
  assign ena_b     = port_b.ena & rst_n;
  assign same_addr = (port_a.addr == port_b.addr);

  // Per-column write resolution: the losing port's column write is dropped.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic both;
    assign col_a[c]  = COL_WIDTH'(col_slice(MAX_WORD_W'(port_a.din), c, COL_WIDTH));
    assign col_b[c]  = COL_WIDTH'(col_slice(MAX_WORD_W'(port_b.din), c, COL_WIDTH));
    assign both      = ena_a & ena_b & same_addr & port_a.we[c] & port_b.we[c];
    assign wr_a[c]   = ena_a & port_a.we[c] & ~(both & (PRIO_A == 0));
    assign wr_b[c]   = ena_b & port_b.we[c] & ~(both & (PRIO_A != 0));
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (wr_a[c]) mem[port_a.addr][c*COL_WIDTH +: COL_WIDTH] <= col_a[c];
      if (wr_b[c]) mem[port_b.addr][c*COL_WIDTH +: COL_WIDTH] <= col_b[c];
    end
  end

  assign old_a = mem[port_a.addr];
  assign old_b = mem[port_b.addr];

  // Post-write view of each port's word: own winning write first, then the
  // other port's winning write when it targets the same address.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int c = 0; c < NUM_COL; c++) begin
      if (wr_a[c])                  new_a[c*COL_WIDTH +: COL_WIDTH] = col_a[c];
      else if (wr_b[c] && same_addr) new_a[c*COL_WIDTH +: COL_WIDTH] = col_b[c];
      if (wr_b[c])                  new_b[c*COL_WIDTH +: COL_WIDTH] = col_b[c];
      else if (wr_a[c] && same_addr) new_b[c*COL_WIDTH +: COL_WIDTH] = col_a[c];
    end
  end

  assign rd_a   = (READ_MODE == RM_WRITE_FIRST) ? new_a : old_a;
  assign rd_b   = (READ_MODE == RM_WRITE_FIRST) ? new_b : old_b;
  assign hold_a = (READ_MODE == RM_NO_CHANGE) && (|port_a.we);
  assign hold_b = (READ_MODE == RM_NO_CHANGE) && (|port_b.we);

  // First read stage; dout holds when the port is idle or a no-change write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout1_a <= '0;
      dout1_b <= '0;
      vld1_a  <= 1'b0;
      vld1_b  <= 1'b0;
      coll1   <= 1'b0;
    end else begin
      vld1_a <= ena_a;
      vld1_b <= ena_b;
      if (ena_a && !hold_a) dout1_a <= rd_a;
      if (ena_b && !hold_b) dout1_b <= rd_b;
      coll1  <= ena_a & ena_b & same_addr & ((|port_a.we) | (|port_b.we));
    end
  end

  bytewrite_ram_outreg #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_or_a (
    .clk(clk), .rst_n(rst_n), .din(dout1_a), .vld_in(vld1_a), .coll_in(coll1),
    .dout(port_a.dout), .vld(port_a.dout_vld), .coll(coll_a)
  );

  bytewrite_ram_outreg #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_or_b (
    .clk(clk), .rst_n(rst_n), .din(dout1_b), .vld_in(vld1_b), .coll_in(coll1),
    .dout(port_b.dout), .vld(port_b.dout_vld), .coll(coll_b)
  );

  // Both stages carry the same flag; either copy is the aligned collision.
  assign coll = coll_a | coll_b;
endmodule
